microseq_sequencer: RTL and testbench

- Parametrised microprogram sequencer. Successor to the team's 4-bit address-slice sequencer.
- Generalised to WIDTH-bit addresses and a STACK_DEPTH-entry subroutine stack.
- Adds occupancy tracking with full/empty flags, plus a loop counter with zero detect.
- Sits between the control-store address bus and the microinstruction decode. Drives the next microaddress each cycle.

---
 rtl/microseq_sequencer.sv | 100 ++++++++++
 tb/tb_microseq_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/microseq_sequencer.sv
// Microprogram sequencer: next-address mux, pc incrementer, subroutine stack, loop counter.
// Optional MICROSEQ_STACK_GUARD_EN blocks stack over/underflow and raises sticky stk_err.
module microseq_sequencer #(
  parameter int WIDTH       = 12,
  parameter int STACK_DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic [1:0]       sel,
  input  logic             zero_n,
  input  logic             cin,
  input  logic             ar_load,
  input  logic [1:0]       stack_op,
  input  logic             cnt_load,
  input  logic             cnt_dec,
  output logic [WIDTH-1:0] yout,
  output logic             cout,
  output logic             cnt_zero,
  output logic             stk_full,
  output logic             stk_empty,
  output logic             stk_err
);

  localparam int PW = $clog2(STACK_DEPTH);
  localparam int OW = PW + 1;

  logic [WIDTH-1:0] pc, ar, cnt;
  logic [WIDTH-1:0] stack [STACK_DEPTH];
  logic [PW-1:0]    sp;
  logic [OW-1:0]    occ;
  logic [PW-1:0]    sp_inc, sp_dec;
  logic [WIDTH-1:0] mux;
  logic             push, pop, do_push, do_pop;

  assign push      = (stack_op == 2'b01);
  assign pop       = (stack_op == 2'b10);
  assign sp_inc    = sp + PW'(1);
  assign sp_dec    = sp - PW'(1);
  assign stk_full  = (occ == OW'(STACK_DEPTH));
  assign stk_empty = (occ == '0);
  assign cnt_zero  = (cnt == '0);

  // A push with sel=10 shows pc, the value about to land on the stack.
  always_comb begin
    mux = pc;
    case (sel)
      2'b00: mux = pc;
      2'b01: mux = ar;
      2'b10: mux = push ? pc : stack[sp];
      2'b11: mux = din;
      default: mux = pc;
    endcase
  end

  assign yout = (reset || !zero_n) ? '0 : mux;
  assign cout = (&yout) & cin;

`ifdef MICROSEQ_STACK_GUARD_EN
  logic err;
  assign do_push = push && !stk_full;
  assign do_pop  = pop && !stk_empty;
  assign stk_err = err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) err <= 1'b0;
    else if ((push && stk_full) || (pop && stk_empty)) err <= 1'b1;
  end
`else
  assign do_push = push;
  assign do_pop  = pop;
  assign stk_err = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc  <= '0;
      ar  <= '0;
      cnt <= '0;
      sp  <= '0;
      occ <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else begin
      pc <= yout + {{(WIDTH-1){1'b0}}, cin};
      if (ar_load) ar <= din;
      if (cnt_load)                 cnt <= din;
      else if (cnt_dec && cnt != '0) cnt <= cnt - WIDTH'(1);
      // Occupancy saturates even when the unguarded pointer wraps.
      if (do_push) begin
        sp            <= sp_inc;
        stack[sp_inc] <= pc;
        if (!stk_full) occ <= occ + OW'(1);
      end else if (do_pop) begin
        sp <= sp_dec;
        if (!stk_empty) occ <= occ - OW'(1);
      end
    end
  end

endmodule

// File: tb/tb_microseq_sequencer.sv
// Randomised scoreboard bench for microseq_sequencer against a behavioural model.
module tb_microseq_sequencer;

  localparam int W = 12;
  localparam int D = 8;
  localparam int MASK = (1 << W) - 1;
`ifdef MICROSEQ_STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] din;
  logic [1:0]   sel;
  logic         zero_n, cin, ar_load, cnt_load, cnt_dec;
  logic [1:0]   stack_op;
  logic [W-1:0] yout;
  logic         cout, cnt_zero, stk_full, stk_empty, stk_err;

  microseq_sequencer #(.WIDTH(W), .STACK_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .din(din), .sel(sel), .zero_n(zero_n),
    .cin(cin), .ar_load(ar_load), .stack_op(stack_op), .cnt_load(cnt_load),
    .cnt_dec(cnt_dec), .yout(yout), .cout(cout), .cnt_zero(cnt_zero),
    .stk_full(stk_full), .stk_empty(stk_empty), .stk_err(stk_err)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural model ----------------
  int m_pc, m_ar, m_cnt, m_sp, m_occ, m_err;
  int m_stk [D];

  int n_cmp = 0;
  int n_fail = 0;
  logic [W+4:0] exp_q [$];

  task automatic model_reset();
    m_pc = 0; m_ar = 0; m_cnt = 0; m_sp = 0; m_occ = 0; m_err = 0;
    for (int i = 0; i < D; i++) m_stk[i] = 0;
  endtask

  function automatic int model_y();
    int v;
    case (sel)
      2'd0: v = m_pc;
      2'd1: v = m_ar;
      2'd2: v = (stack_op == 2'd1) ? m_pc : m_stk[m_sp];
      default: v = int'(din);
    endcase
    return zero_n ? v : 0;
  endfunction

  function automatic logic [W+4:0] model_out();
    int y;
    logic [W+4:0] r;
    y = model_y();
    r[W+4:5] = W'(y);
    r[4] = (y == MASK) && cin;
    r[3] = (m_cnt == 0);
    r[2] = (m_occ == D);
    r[1] = (m_occ == 0);
    r[0] = (m_err != 0);
    return r;
  endfunction

  task automatic model_edge();
    int y, old_pc;
    y = model_y();
    old_pc = m_pc;
    m_pc = (y + int'(cin)) % (MASK + 1);
    if (ar_load) m_ar = int'(din);
    if (cnt_load) m_cnt = int'(din);
    else if (cnt_dec && m_cnt > 0) m_cnt = m_cnt - 1;
    if (stack_op == 2'd1) begin
      if (GUARD && m_occ == D) m_err = 1;
      else begin
        m_sp = (m_sp + 1) % D;
        m_stk[m_sp] = old_pc;
        if (m_occ < D) m_occ++;
      end
    end else if (stack_op == 2'd2) begin
      if (GUARD && m_occ == 0) m_err = 1;
      else begin
        m_sp = (m_sp + D - 1) % D;
        if (m_occ > 0) m_occ--;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic set_in(input logic [1:0] s, input int d, input logic z, input logic c,
                        input logic al, input logic [1:0] op, input logic cl, input logic cd);
    sel = s; din = W'(d); zero_n = z; cin = c; ar_load = al;
    stack_op = op; cnt_load = cl; cnt_dec = cd;
    exp_q.push_back(model_out());
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic hold(input logic [1:0] s, input logic c);
    set_in(s, 0, 1'b1, c, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int d);
    reset = 1'b1;
    sel = 2'd3; din = W'(d); zero_n = 1'b1; cin = 1'b1;
    #1;
    model_reset();
    chk("reset_yout", int'(yout), 0);
    chk("reset_cout", int'(cout), 0);
    chk("reset_empty", int'(stk_empty), 1);
    chk("reset_full", int'(stk_full), 0);
    chk("reset_cnt_zero", int'(cnt_zero), 1);
    chk("reset_err", int'(stk_err), 0);
    #2;
    reset = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (!reset && exp_q.size() > 0) begin
      logic [W+4:0] e, a;
      e = exp_q.pop_front();
      a = {yout, cout, cnt_zero, stk_full, stk_empty, stk_err};
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL scoreboard: got y=%h c=%b z=%b f=%b e=%b err=%b expected y=%h c=%b z=%b f=%b e=%b err=%b",
                 a[W+4:5], a[4], a[3], a[2], a[1], a[0], e[W+4:5], e[4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    din = '0; sel = 2'd0; zero_n = 1'b1; cin = 1'b0; ar_load = 1'b0;
    stack_op = 2'd0; cnt_load = 1'b0; cnt_dec = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    do_reset(16'h5A5);

    // Counting from reset: 0,1,2,3
    for (int i = 0; i < 4; i++) begin
      hold(2'd0, 1'b1); #1; chk("count_seq", int'(yout), i); tick();
    end

    // Branch to all-ones with carry wraps pc to 0
    set_in(2'd3, 'hFFF, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    #1; chk("branch_cout", int'(cout), 1); tick();
    hold(2'd0, 1'b0); #1; chk("wrap_pc", int'(yout), 0); tick();
    set_in(2'd3, 'h5A5, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    #1; chk("zero_n_yout", int'(yout), 0); tick();
    hold(2'd0, 1'b0); #1; chk("zero_n_pc", int'(yout), 1); tick();

    // Call / return
    set_in(2'd3, 'h010, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0); tick();
    set_in(2'd3, 'h200, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
    #1; chk("call_yout", int'(yout), 'h200); tick();
    hold(2'd0, 1'b1); tick();
    set_in(2'd2, 0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
    #1; chk("return_yout", int'(yout), 'h010); tick();
    hold(2'd0, 1'b0); #1; chk("return_empty", int'(stk_empty), 1); tick();

    // Fill the stack, then one extra push
    for (int i = 0; i < D; i++) begin
      set_in(2'd0, 0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0); tick();
    end
    hold(2'd0, 1'b0); #1; chk("full_after_8", int'(stk_full), 1); tick();
    set_in(2'd0, 0, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0); tick();
    hold(2'd0, 1'b0); #1; chk("full_after_9", int'(stk_full), 1);
`ifdef MICROSEQ_STACK_GUARD_EN
    chk("overflow_err", int'(stk_err), 1);
`else
    chk("no_guard_err", int'(stk_err), 0);
`endif
    tick();
    for (int i = 0; i < D + 1; i++) begin
      set_in(2'd2, 0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0); tick();
    end

    // Loop counter
    set_in(2'd0, 3, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0); tick();
    for (int i = 0; i < 4; i++) begin
      set_in(2'd0, 0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
      #1; chk("cnt_before_dec", int'(cnt_zero), (i >= 3) ? 1 : 0); tick();
    end
    set_in(2'd0, 5, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1); tick();
    for (int i = 0; i < 5; i++) begin
      set_in(2'd0, 0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
      #1; chk("cnt_load5", int'(cnt_zero), 0); tick();
    end
    hold(2'd0, 1'b0); #1; chk("cnt_load5_zero", int'(cnt_zero), 1); tick();

    // Push write-through
    do_reset(0);
    set_in(2'd3, 'h123, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0); tick();
    set_in(2'd2, 0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
    #1; chk("wt_yout", int'(yout), 'h123); tick();
    hold(2'd2, 1'b0); #1; chk("wt_top", int'(yout), 'h123); tick();

    // Randomised traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      int d;
      if ($urandom_range(0, 499) == 0) do_reset(int'($urandom_range(0, MASK)));
      d = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, MASK));
      set_in(2'($urandom_range(0, 3)), d, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom_range(0, 7) == 0,
             1'($urandom_range(0, 1)));
      tick();
    end
    @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
